// File: rtl/fpu_col_sequencer.sv
// Column-fetch sequencer for the FPU column buffers: fetches one column at a time,
// strobes the buffer shift on arrival, and offers 3-column windows to the FPU.
module fpu_col_sequencer #(
  parameter int COL_WIDTH = 10,
  parameter int W_BITS    = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [W_BITS-1:0] img_width,
  output logic              col_req,
  output logic [W_BITS-1:0] col_idx,
  input  logic              col_gnt,
  input  logic              col_vld,
  output logic              shift_cols,
  output logic              win_valid,
  input  logic              win_ready,
  output logic              busy,
  output logic              done,
  output logic              err
);

  if (COL_WIDTH < 1) begin : g_bad_cfg
    $error("COL_WIDTH must be at least 1");
  end

  localparam logic [W_BITS-1:0] MIN_WIDTH = W_BITS'(3);

  // IDLE wait start | REQ fetch requested | WAIT granted, awaiting data | WIN window offered | DONE done pulse
  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_WIN, S_DONE} state_t;

  state_t            state, state_nxt;
  logic [W_BITS-1:0] width_q;
  logic [W_BITS-1:0] idx_q;
  logic [1:0]        loaded_q;
  logic [1:0]        loaded_inc;
  logic              err_q;
  logic              start_ok;

  assign start_ok   = (state == S_IDLE) && start && (img_width >= MIN_WIDTH);
  assign loaded_inc = (loaded_q == 2'd3) ? 2'd3 : loaded_q + 2'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start_ok) state_nxt = S_REQ;
      S_REQ:  if (col_gnt) state_nxt = S_WAIT;
      S_WAIT: if (col_vld) state_nxt = (loaded_inc == 2'd3) ? S_WIN : S_REQ;
      S_WIN:  if (win_ready) state_nxt = (idx_q == width_q) ? S_DONE : S_REQ;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      width_q  <= '0;
      idx_q    <= '0;
      loaded_q <= '0;
      err_q    <= 1'b0;
    end else begin
      err_q <= (state == S_IDLE) && start && (img_width < MIN_WIDTH);
      if (start_ok) begin
        width_q  <= img_width;
        idx_q    <= '0;
        loaded_q <= '0;
      end else if ((state == S_WAIT) && col_vld) begin
        idx_q    <= idx_q + W_BITS'(1);
        loaded_q <= loaded_inc;
      end
    end
  end

  // Shift is combinational so it lines up with the column data on col_new.
  assign shift_cols = (state == S_WAIT) && col_vld;
  assign col_req    = (state == S_REQ);
  assign win_valid  = (state == S_WIN);
  assign busy       = (state != S_IDLE);
  assign done       = (state == S_DONE);
  assign err        = err_q;
  assign col_idx    = idx_q;

endmodule
